// File: rtl/stream_checker_pkg.sv
// Shared types and widths for the stream checker: FSM encoding, data and
// frame counter widths, and saturating increment helpers.
package stream_checker_pkg;

   localparam int DATA_W = 8;
   localparam int FCNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } sc_state_t;

   function automatic logic [DATA_W-1:0] sat_inc_data(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [FCNT_W-1:0] sat_inc_fcnt(input logic [FCNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sc_buffer.sv
// Capture RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sc_buffer
   import stream_checker_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_checker.sv
// Receives AXI-Stream frames, captures them into a buffer and checks each
// beat against an incrementing pattern seeded by the first beat.
module stream_checker
   import stream_checker_pkg::*;
#(
   parameter int DEPTH_AW = 8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en_check,
   input  logic [7:0]  frame_size,
   input  logic        clr,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   input  logic [7:0]  s_axis_tdata,
   output logic        done,
   output logic [7:0]  err_count,
   output logic        len_err,
   output logic [15:0] frame_count,
   input  logic [7:0]  rd_addr,
   output logic [7:0]  rd_data
);

   sc_state_t         state;
   logic [7:0]        ptr;
   logic [DATA_W-1:0] seed;

   logic accept;
   logic wr_en;
   logic beat_bad;

   // Handshake: a beat transfers on a rising edge where tvalid && tready;
   // tready depends only on the state register.
   assign s_axis_tready = (state == S_RECV) || (state == S_DRAIN);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign wr_en         = accept && (state == S_RECV);
   assign beat_bad      = (ptr != 8'd0) && (s_axis_tdata != seed + ptr);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         seed        <= '0;
         done        <= 1'b0;
         err_count   <= '0;
         len_err     <= 1'b0;
         frame_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en_check) begin
                  state     <= S_RECV;
                  ptr       <= '0;
                  err_count <= '0;
                  len_err   <= 1'b0;
               end
            end

            S_RECV: begin
               // A beat accepted in the abort cycle is still captured and checked.
               if (accept) begin
                  ptr <= ptr + 8'd1;
                  if (ptr == 8'd0)   seed      <= s_axis_tdata;
                  else if (beat_bad) err_count <= sat_inc_data(err_count);
               end
               if (!en_check) begin
                  state <= S_IDLE;
               end else if (accept) begin
                  if (s_axis_tlast) begin
                     if (ptr != frame_size) len_err <= 1'b1;
                     state       <= S_DONE;
                     done        <= 1'b1;
                     frame_count <= sat_inc_fcnt(frame_count);
                  end else if (ptr >= frame_size) begin
                     len_err <= 1'b1;
                     state   <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               if (!en_check) begin
                  state <= S_IDLE;
               end else if (accept && s_axis_tlast) begin
                  state       <= S_DONE;
                  done        <= 1'b1;
                  frame_count <= sat_inc_fcnt(frame_count);
               end
            end

            S_DONE: begin
               if (clr) begin
                  done <= 1'b0;
                  if (en_check) begin
                     state     <= S_RECV;
                     ptr       <= '0;
                     err_count <= '0;
                     len_err   <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   sc_buffer #(.AW(DEPTH_AW)) u_buffer (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (DEPTH_AW'(ptr)),
      .wr_data (s_axis_tdata),
      .rd_addr (DEPTH_AW'(rd_addr)),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: directed and random frames compared against a
// frame-level model of expected errors, length flag, count and buffer.
module tb_stream_checker;

   logic        clk = 1'b0;
   logic        nrst;
   logic        en_check;
   logic [7:0]  frame_size;
   logic        clr;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic [7:0]  tdata;
   logic        done;
   logic [7:0]  err_count;
   logic        len_err;
   logic [15:0] frame_count;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          fc_exp   = 0;
   logic [7:0]  beat_d [64];
   logic [7:0]  mem_model [32];
   bit          mem_known [32];
   logic [7:0]  exp_q [$];
   int          addr_q [$];

   always #5 clk = ~clk;

   stream_checker #(.DEPTH_AW(8)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .en_check      (en_check),
      .frame_size    (frame_size),
      .clr           (clr),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .s_axis_tlast  (tlast),
      .s_axis_tdata  (tdata),
      .done          (done),
      .err_count     (err_count),
      .len_err       (len_err),
      .frame_count   (frame_count),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_seq(input int n, input int base);
      for (int i = 0; i < n; i++) beat_d[i] = 8'(base + i);
   endtask

   // Drives beats 0..n-1 of beat_d; tlast on the final beat only if send_last.
   task automatic drive_frame(input int n, input int gap_max, input bit send_last, input bit clr_on_last);
      for (int i = 0; i < n; i++) begin
         int g;
         int w;
         g = $urandom_range(0, gap_max);
         repeat (g) begin
            @(negedge clk);
            tvalid = 1'b0;
         end
         @(negedge clk);
         tvalid = 1'b1;
         tdata  = beat_d[i];
         tlast  = send_last && (i == n - 1);
         clr    = clr_on_last && (i == n - 1);
         w = 0;
         while (!tready && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (w >= 50) begin
            check_eq("tready_timeout", 32'(tready), 32'd1);
            tvalid = 1'b0;
            tlast  = 1'b0;
            clr    = 1'b0;
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      clr    = 1'b0;
      #1;
   endtask

   task automatic check_buffer(input string name);
      for (int a = 0; a < 32; a++) begin
         if (mem_known[a]) begin
            exp_q.push_back(mem_model[a]);
            addr_q.push_back(a);
         end
      end
      while (exp_q.size() > 0) begin
         rd_addr = 8'(addr_q.pop_front());
         #1;
         check_eq($sformatf("%s.rd_data[%0d]", name, rd_addr), 32'(rd_data), 32'(exp_q.pop_front()));
      end
   endtask

   // Frame-level model: tlast on beat n-1, frame_size constant for the frame.
   task automatic model_and_check(input int n, input string name);
      int last_idx;
      int fs;
      int written;
      int errs;
      bit len_exp;
      last_idx = n - 1;
      fs       = int'(frame_size);
      written  = (last_idx < fs) ? last_idx : fs;
      errs     = 0;
      for (int i = 1; i <= written; i++)
         if (beat_d[i] != 8'(int'(beat_d[0]) + i) && errs < 255) errs++;
      len_exp = (last_idx != fs);
      fc_exp  = (fc_exp < 65535) ? fc_exp + 1 : fc_exp;
      for (int i = 0; i <= written; i++) begin
         mem_model[i] = beat_d[i];
         mem_known[i] = 1'b1;
      end
      check_eq({name, ".done"},        32'(done),        32'd1);
      check_eq({name, ".err_count"},   32'(err_count),   32'(errs));
      check_eq({name, ".len_err"},     32'(len_err),     32'(len_exp));
      check_eq({name, ".frame_count"}, 32'(frame_count), 32'(fc_exp));
      check_eq({name, ".tready"},      32'(tready),      32'd0);
      check_buffer(name);
   endtask

   task automatic do_clr(input bit en);
      @(negedge clk);
      clr      = 1'b1;
      en_check = en;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check_eq("done_after_clr", 32'(done), 32'd0);
   endtask

   task automatic check_reset_values(input string name);
      check_eq({name, ".done"},        32'(done),        32'd0);
      check_eq({name, ".err_count"},   32'(err_count),   32'd0);
      check_eq({name, ".len_err"},     32'(len_err),     32'd0);
      check_eq({name, ".frame_count"}, 32'(frame_count), 32'd0);
      check_eq({name, ".tready"},      32'(tready),      32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst       = 1'b0;
      en_check   = 1'b0;
      clr        = 1'b0;
      tvalid     = 1'b0;
      tlast      = 1'b0;
      tdata      = 8'h00;
      frame_size = 8'd7;
      rd_addr    = 8'h00;
      for (int a = 0; a < 32; a++) mem_known[a] = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check_reset_values("reset");
      nrst = 1'b1;

      // Good frame, tvalid held high.
      en_check = 1'b1;
      fill_seq(8, 'h10);
      drive_frame(8, 0, 1'b1, 1'b0);
      model_and_check(8, "basic");

      // One corrupted beat; clr coincident with DONE entry must be ignored.
      do_clr(1'b1);
      fill_seq(8, 'h10);
      beat_d[3] = 8'hFF;
      drive_frame(8, 0, 1'b1, 1'b1);
      model_and_check(8, "bad_beat");

      // Early tlast, then a further beat must not be taken.
      do_clr(1'b1);
      fill_seq(5, 'h40);
      drive_frame(5, 0, 1'b1, 1'b0);
      model_and_check(5, "early_last");
      tvalid = 1'b1;
      tdata  = 8'h99;
      tlast  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_eq("early_last.extra_tready", 32'(tready),      32'd0);
      check_eq("early_last.extra_fcnt",   32'(frame_count), 32'(fc_exp));
      check_eq("early_last.extra_done",   32'(done),        32'd1);
      tvalid = 1'b0;
      tlast  = 1'b0;

      // Late tlast: beats past frame_size drained without writing.
      frame_size = 8'd3;
      do_clr(1'b1);
      fill_seq(6, 'h60);
      drive_frame(6, 0, 1'b1, 1'b0);
      model_and_check(6, "late_last");

      // Random frames with tvalid gaps, including single-beat frames.
      for (int k = 0; k < 10; k++) begin
         int fs;
         int last_idx;
         int base;
         fs       = (k == 0) ? 0 : $urandom_range(0, 12);
         last_idx = (k == 0) ? 0 : $urandom_range(0, fs + 3);
         base     = $urandom_range(0, 255);
         frame_size = 8'(fs);
         do_clr(1'b1);
         for (int i = 0; i <= last_idx; i++)
            beat_d[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
         drive_frame(last_idx + 1, 3, 1'b1, 1'b0);
         model_and_check(last_idx + 1, $sformatf("rand%0d", k));
      end

      // Abort: en_check drops while beat 2 is accepted (beat 2 corrupted).
      frame_size = 8'd7;
      do_clr(1'b1);
      fill_seq(2, 'h30);
      drive_frame(2, 0, 1'b0, 1'b0);
      @(negedge clk);
      tvalid   = 1'b1;
      tdata    = 8'h00;
      tlast    = 1'b0;
      en_check = 1'b0;
      #1;
      check_eq("abort.tready_before", 32'(tready), 32'd1);
      @(negedge clk);
      tvalid = 1'b0;
      #1;
      check_eq("abort.tready",      32'(tready),      32'd0);
      check_eq("abort.done",        32'(done),        32'd0);
      check_eq("abort.frame_count", 32'(frame_count), 32'(fc_exp));
      check_eq("abort.err_count",   32'(err_count),   32'd1);
      check_eq("abort.len_err",     32'(len_err),     32'd0);
      mem_model[0] = 8'h30;
      mem_model[1] = 8'h31;
      mem_model[2] = 8'h00;
      mem_known[0] = 1'b1;
      mem_known[1] = 1'b1;
      mem_known[2] = 1'b1;
      check_buffer("abort");
      repeat (2) @(negedge clk);
      #1;
      check_eq("abort.idle_tready", 32'(tready), 32'd0);

      // Reset in the middle of a frame; buffer keeps what was written.
      en_check = 1'b1;
      fill_seq(3, 'h70);
      drive_frame(3, 1, 1'b0, 1'b0);
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      #1;
      check_reset_values("mid_reset");
      fc_exp = 0;
      for (int i = 0; i < 3; i++) begin
         mem_model[i] = beat_d[i];
         mem_known[i] = 1'b1;
      end
      check_buffer("mid_reset");
      nrst     = 1'b1;
      en_check = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 The parameter shall be DEPTH_AW, default 8, meaning the capture buffer address width (2^DEPTH_AW entries of 8 bits).
REQ-002 Port clk  input  1  is the system clock; all logic shall be rising-edge.
REQ-003 Port nrst  input  1  is the reset: synchronous, active-low.
REQ-004 Port en_check  input  1  shall enable frame reception.
REQ-005 Port frame_size  input  8  shall give the index of the last beat; a frame is frame_size+1 beats.
REQ-006 Port clr  input  1  shall acknowledge done.
REQ-007 Port s_axis_tvalid  input  1  is the AXI-Stream slave valid.
REQ-008 Port s_axis_tready  output  1  is the AXI-Stream slave ready.
REQ-009 Port s_axis_tlast  input  1  is the AXI-Stream end-of-frame marker.
REQ-010 Port s_axis_tdata  input  8  is the AXI-Stream payload.
REQ-011 Port done  output  1  shall be the frame-complete flag, latched until clr.
REQ-012 Port err_count  output  8  shall count data-mismatch beats in the last frame.
REQ-013 Port len_err  output  1  shall flag that tlast was early or missing in the last frame.
REQ-014 Port frame_count  output  16  shall count completed frames.
REQ-015 Port rd_addr  input  8  is the software read address into the capture buffer.
REQ-016 Port rd_data  output  8  shall return the buffer contents at rd_addr, combinationally.

Function
REQ-017 The FSM shall have four states: S_IDLE, S_RECV, S_DRAIN and S_DONE.
REQ-018 S_IDLE shall go to S_RECV when en_check=1; on entry to S_RECV, ptr, err_count and len_err shall clear to 0.
REQ-019 s_axis_tready shall be 1 exactly in S_RECV and S_DRAIN, decoded from state with no combinational path from inputs.
REQ-020 A beat is accepted when tvalid&&tready; in S_RECV, an accepted beat shall write tdata to buffer[ptr] and then increment ptr (8-bit).
REQ-021 On the first beat (ptr=0), the seed shall be set to tdata and that beat shall not be checked.
REQ-022 Each later beat shall be compared with (seed+ptr) mod 256; a mismatch shall increment err_count, saturating at 255.
REQ-023 Accepted tlast with ptr==frame_size shall give a good end: go to S_DONE.
REQ-024 Accepted tlast with ptr<frame_size shall set len_err=1 and go to S_DONE.
REQ-025 An accepted beat with ptr==frame_size and tlast=0 shall set len_err=1 and go to S_DRAIN.
REQ-026 S_DRAIN shall accept and discard beats (no buffer write, no check) until an accepted tlast, then go to S_DONE.
REQ-027 On every transition into S_DONE, done shall be set to 1 and frame_count shall increment, saturating at 0xFFFF.
REQ-028 In S_DONE, tready shall be 0 and done shall hold until clr=1; then the FSM shall go to S_RECV if en_check=1, else to S_IDLE, and done shall go to 0.
REQ-029 A clr in the same cycle as the transition into S_DONE shall be ignored.
REQ-030 When en_check=0 in S_RECV or S_DRAIN, the FSM shall abort to S_IDLE next cycle: the frame is dropped, frame_count is unchanged, and err_count/len_err hold.
REQ-031 An accepted beat in the abort cycle shall still be written to the buffer and checked.
REQ-032 A frame_size change mid-frame shall take effect on the next beat compare.
REQ-033 frame_size=0 shall mean a single-beat frame: tlast must be on beat 0.
REQ-034 err_count, len_err and the buffer shall hold their values through S_DONE and S_IDLE until the next S_RECV entry.

Reset
REQ-035 With nrst=0 at a clk edge: state=S_IDLE, ptr=0, seed=0, done=0, err_count=0, len_err=0, frame_count=0, and s_axis_tready=0.
REQ-036 Buffer contents shall not be reset.
REQ-037 A reset mid-frame shall discard the frame, with no done pulse.

Structure
REQ-038 Package stream_checker_pkg shall hold the state encoding (2-bit, IDLE=0, RECV=1, DRAIN=2, DONE=3), the data width 8 and the frame_count width 16.
REQ-039 Sub-module sc_buffer shall be the 2^DEPTH_AW x 8 RAM, with a single synchronous write port and an asynchronous read port driving rd_data.

Verification
REQ-040 en_check=1, frame_size=7, beats 0x10..0x17 with tlast on the 8th, tvalid held high -> done=1, err_count=0, len_err=0, frame_count=1, buffer[0..7]=0x10..0x17.
REQ-041 Same frame with beat 3 set to 0xFF -> err_count=1, len_err=0, done=1.
REQ-042 frame_size=7, tlast on beat 4 -> len_err=1, done=1, frame_count=1; a further beat is not accepted (tready=0).
REQ-043 frame_size=3, 6 beats with tlast on the 6th -> len_err=1, beats 4-5 accepted in S_DRAIN and not written, done=1.
REQ-044 Random tvalid gaps, then clr pulsed in S_DONE with en_check=1 -> done=0 next cycle, second frame received, frame_count=2.
REQ-045 en_check dropped after beat 2 of 8 -> S_IDLE, tready=0, done=0, frame_count unchanged; nrst=0 mid-frame -> all outputs at reset values.
